// File: rtl/dm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm : shared DTM types - DTMCS register layout and JTAG instruction codes
// Revision: 1.0
// ---------------------------------------------------------------------------
package dm;

  typedef enum logic [4:0] {
    BYPASS0   = 5'h00,
    IDCODE    = 5'h01,
    DTMCSR    = 5'h10,
    DMIACCESS = 5'h11,
    BYPASS1   = 5'h1f
  } ir_reg_e;

  typedef struct packed {
    logic [31:18] zero1;
    logic         dmihardreset;
    logic         dmireset;
    logic         zero0;
    logic [2:0]   idle;
    logic [1:0]   dmistat;
    logic [5:0]   abits;
    logic [3:0]   version;
  } dtmcs_t;

endpackage
`default_nettype wire

// File: rtl/dmi_tap_ctrl_clk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tc_clk_inverter / tc_clk_mux2 : clock cells for the TDO output register
// Revision: 1.0
// ---------------------------------------------------------------------------
module tc_clk_inverter (
  input  logic clk_i,
  output logic clk_no
);
  assign clk_no = ~clk_i;
endmodule

module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);
  assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule
`default_nettype wire

// File: rtl/dmi_tap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmi_tap_ctrl : IEEE 1149.1 TAP controller and IR/DR front end for the DTM
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmi_tap_ctrl
  import dm::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       td_i,
  output logic       td_o,
  output logic       tdo_oe_o,
  input  logic       testmode_i,
  output logic       test_logic_reset_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_dr_o,
  output logic       dmi_access_o,
  output logic       dtmcs_select_o,
  output logic       dmi_reset_o,
  input  logic [1:0] dmi_error_i,
  output logic       dmi_tdi_o,
  input  logic       dmi_tdo_i
);

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr,
    ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
    SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
  } tap_state_e;

  tap_state_e          state_q;
  logic [IrLength-1:0] ir_q, ir_shift_q;
  logic [31:0]         idcode_q, idcode_d;
  dtmcs_t              dtmcs_q, dtmcs_d;
  logic                bypass_q, bypass_d;
  logic                sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;
  logic                tdo_mux, tck_n, tdo_clk;
  logic                td_q, tdo_oe_q;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= TestLogicReset;
    end else begin
      case (state_q)
        TestLogicReset: state_q <= tms_i ? TestLogicReset : RunTestIdle;
        RunTestIdle:    state_q <= tms_i ? SelectDrScan   : RunTestIdle;
        SelectDrScan:   state_q <= tms_i ? SelectIrScan   : CaptureDr;
        CaptureDr:      state_q <= tms_i ? Exit1Dr        : ShiftDr;
        ShiftDr:        state_q <= tms_i ? Exit1Dr        : ShiftDr;
        Exit1Dr:        state_q <= tms_i ? UpdateDr       : PauseDr;
        PauseDr:        state_q <= tms_i ? Exit2Dr        : PauseDr;
        Exit2Dr:        state_q <= tms_i ? UpdateDr       : ShiftDr;
        UpdateDr:       state_q <= tms_i ? SelectDrScan   : RunTestIdle;
        SelectIrScan:   state_q <= tms_i ? TestLogicReset : CaptureIr;
        CaptureIr:      state_q <= tms_i ? Exit1Ir        : ShiftIr;
        ShiftIr:        state_q <= tms_i ? Exit1Ir        : ShiftIr;
        Exit1Ir:        state_q <= tms_i ? UpdateIr       : PauseIr;
        PauseIr:        state_q <= tms_i ? Exit2Ir        : PauseIr;
        Exit2Ir:        state_q <= tms_i ? UpdateIr       : ShiftIr;
        UpdateIr:       state_q <= tms_i ? SelectDrScan   : RunTestIdle;
        default:        state_q <= TestLogicReset;
      endcase
    end
  end

  assign test_logic_reset_o = (state_q == TestLogicReset);
  assign shift_dr_o         = (state_q == ShiftDr);
  assign update_dr_o        = (state_q == UpdateDr);
  assign capture_dr_o       = (state_q == CaptureDr);

  // IR is also forced on the edge entering Test-Logic-Reset, so decodes are clean there.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q       <= IrLength'(IDCODE);
      ir_shift_q <= '0;
    end else if (state_q == TestLogicReset || (state_q == SelectIrScan && tms_i)) begin
      ir_q <= IrLength'(IDCODE);
    end else begin
      case (state_q)
        CaptureIr: ir_shift_q <= IrLength'(5'b00101);
        ShiftIr:   ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};
        UpdateIr:  ir_q       <= ir_shift_q;
        default:   ;
      endcase
    end
  end

  assign sel_idcode     = (ir_q == IrLength'(IDCODE));
  assign sel_dtmcs      = (ir_q == IrLength'(DTMCSR));
  assign sel_dmi        = (ir_q == IrLength'(DMIACCESS));
  assign sel_bypass     = !(sel_idcode || sel_dtmcs || sel_dmi);
  assign dmi_access_o   = sel_dmi;
  assign dtmcs_select_o = sel_dtmcs;
  assign dmi_tdi_o      = td_i;
  assign dmi_reset_o    = (state_q == UpdateDr) && sel_dtmcs && dtmcs_q.dmireset;

  always_comb begin
    idcode_d = idcode_q;
    dtmcs_d  = dtmcs_q;
    bypass_d = bypass_q;
    if (state_q == CaptureDr) begin
      if (sel_idcode) idcode_d = IdcodeValue | 32'h1;
      if (sel_dtmcs) begin
        dtmcs_d         = '0;
        dtmcs_d.version = 4'd1;
        dtmcs_d.abits   = 6'd7;
        dtmcs_d.dmistat = dmi_error_i;
        dtmcs_d.idle    = 3'd1;
      end
      if (sel_bypass) bypass_d = 1'b0;
    end else if (state_q == ShiftDr) begin
      if (sel_idcode) idcode_d = {td_i, idcode_q[31:1]};
      if (sel_dtmcs)  dtmcs_d  = dtmcs_t'({td_i, dtmcs_q[31:1]});
      if (sel_bypass) bypass_d = td_i;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= '0;
      dtmcs_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      idcode_q <= idcode_d;
      dtmcs_q  <= dtmcs_d;
      bypass_q <= bypass_d;
    end
  end

  always_comb begin
    tdo_mux = 1'b0;
    if (state_q == ShiftIr) begin
      tdo_mux = ir_shift_q[0];
    end else if (state_q == ShiftDr) begin
      if (sel_idcode)     tdo_mux = idcode_q[0];
      else if (sel_dtmcs) tdo_mux = dtmcs_q[0];
      else if (sel_dmi)   tdo_mux = dmi_tdo_i;
      else                tdo_mux = bypass_q;
    end
  end

  tc_clk_inverter u_tck_inv (
    .clk_i  (tck_i),
    .clk_no (tck_n)
  );

  tc_clk_mux2 u_tdo_clk_mux (
    .clk0_i    (tck_n),
    .clk1_i    (tck_i),
    .clk_sel_i (testmode_i),
    .clk_o     (tdo_clk)
  );

  always_ff @(posedge tdo_clk or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= tdo_mux;
      tdo_oe_q <= (state_q == ShiftIr) || (state_q == ShiftDr);
    end
  end

  assign td_o     = td_q;
  assign tdo_oe_o = tdo_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_dmi_tap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmi_tap_ctrl : directed + randomized bench for dmi_tap_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dmi_tap_ctrl;

  localparam logic [31:0] IDV = 32'h4A5B_6C7E;

  localparam int TLR = 0,  RTI = 1,  SDR = 2,  CDR = 3,  SHDR = 4,  E1DR = 5,  PDR = 6,  E2DR = 7;
  localparam int UDR = 8,  SIR = 9,  CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

  int nxt0 [16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI, CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
  int nxt1 [16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR, TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

  logic       tck = 1'b0;
  logic       trst_ni = 1'b0;
  logic       tms_i = 1'b0;
  logic       td_i = 1'b0;
  logic       testmode_i = 1'b0;
  logic       dmi_tdo_i = 1'b0;
  logic [1:0] dmi_error_i = 2'b00;
  logic       td_o, tdo_oe_o, test_logic_reset_o, shift_dr_o, update_dr_o, capture_dr_o;
  logic       dmi_access_o, dtmcs_select_o, dmi_reset_o, dmi_tdi_o;

  int n_pass = 0;
  int n_total = 0;
  int m_state = TLR;
  int ir_m = 1;
  int n_rst_pulse = 0;

  dmi_tap_ctrl #(.IrLength(5), .IdcodeValue(IDV)) dut (
    .tck_i              (tck),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .td_i               (td_i),
    .td_o               (td_o),
    .tdo_oe_o           (tdo_oe_o),
    .testmode_i         (testmode_i),
    .test_logic_reset_o (test_logic_reset_o),
    .shift_dr_o         (shift_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_dr_o       (capture_dr_o),
    .dmi_access_o       (dmi_access_o),
    .dtmcs_select_o     (dtmcs_select_o),
    .dmi_reset_o        (dmi_reset_o),
    .dmi_error_i        (dmi_error_i),
    .dmi_tdi_o          (dmi_tdi_o),
    .dmi_tdo_i          (dmi_tdo_i)
  );

  always #10 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One TCK cycle: check decodes for the current state, sample TDO, advance.
  task automatic step(input logic tms, input logic tdi, input logic dtdo, output logic tdo);
    chk("tlr",          test_logic_reset_o, m_state == TLR);
    chk("shift_dr",     shift_dr_o,         m_state == SHDR);
    chk("update_dr",    update_dr_o,        m_state == UDR);
    chk("capture_dr",   capture_dr_o,       m_state == CDR);
    chk("tdo_oe",       tdo_oe_o,           (m_state == SHDR) || (m_state == SHIR));
    chk("dmi_access",   dmi_access_o,       ir_m == 32'h11);
    chk("dtmcs_select", dtmcs_select_o,     ir_m == 32'h10);
    tdo = td_o;
    if (dmi_reset_o) n_rst_pulse++;
    tms_i = tms;
    td_i  = tdi;
    #1;
    chk("dmi_tdi", dmi_tdi_o, tdi);
    @(posedge tck);
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
    if (m_state == TLR) ir_m = 1;
    dmi_tdo_i = dtdo;
    @(negedge tck);
    #1;
  endtask

  function automatic logic [31:0] cap_value(input int ir, input logic [1:0] err);
    if (ir == 1)  return IDV | 32'h1;
    if (ir == 16) return 32'h1 | (32'd7 << 4) | ({30'd0, err} << 10) | (32'd1 << 12);
    return 32'h0;
  endfunction

  task automatic shift_ir(input logic [4:0] v);
    logic [4:0] cap;
    logic       b;
    step(1, 0, 0, b); step(1, 0, 0, b); step(0, 0, 0, b); step(0, 0, 0, b);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, v[i], 0, b);
      cap[i] = b;
    end
    step(1, 0, 0, b);
    step(0, 0, 0, b);
    ir_m = int'(v);
    chk("ir_capture", {27'd0, cap}, 32'h5);
  endtask

  task automatic shift_dr(input logic [31:0] din, input int n, input logic [31:0] dpat);
    logic [31:0] dout, exp, capv;
    logic        b;
    dout = '0;
    exp  = '0;
    capv = cap_value(ir_m, dmi_error_i);
    n_rst_pulse = 0;
    step(1, 0, 0, b); step(0, 0, 0, b); step(0, 0, dpat[0], b);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], (i < 31) ? dpat[i+1] : 1'b0, b);
      dout[i] = b;
      if (ir_m == 17)                   exp[i] = dpat[i];
      else if (ir_m == 1 || ir_m == 16) exp[i] = capv[i];
      else if (i == 0)                  exp[i] = 1'b0;
      else                              exp[i] = din[i-1];
    end
    step(1, 0, 0, b);
    step(0, 0, 0, b);
    step(0, 0, 0, b);
    chk("dr_out", dout, exp);
    chk("dmi_reset_cycles", n_rst_pulse, (ir_m == 16 && n == 32 && din[16]) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [4:0]  irs [7];
    logic [4:0]  ir;
    logic        b;
    int          n;
    irs = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h1f, 5'h07, 5'h0a};

    @(negedge tck); #1;
    chk("rst_tlr",    test_logic_reset_o, 1);
    chk("rst_td_o",   td_o, 0);
    chk("rst_oe",     tdo_oe_o, 0);
    chk("rst_dmi",    dmi_access_o, 0);
    chk("rst_dtmcs",  dtmcs_select_o, 0);
    chk("rst_dmirst", dmi_reset_o, 0);
    trst_ni = 1'b1;
    m_state = TLR;
    ir_m    = 1;

    step(0, 0, 0, b);
    shift_dr($urandom, 32, 32'h0);

    shift_ir(5'h11);
    chk("dmi_access_after_update", dmi_access_o, 1);
    shift_ir(5'h11);
    shift_dr($urandom, 32, $urandom);

    shift_ir(5'h10);
    dmi_error_i = 2'b11;
    shift_dr(32'h0001_0000, 32, 32'h0);
    shift_dr(32'h0000_0000, 32, 32'h0);

    shift_ir(5'h1f);
    shift_dr(32'hb, 4, 32'h0);
    shift_ir(5'h07);
    shift_dr(32'hb, 4, 32'h0);

    for (int k = 0; k < 24; k++) begin
      ir = irs[$urandom_range(0, 6)];
      if (k % 7 == 6) ir = 5'($urandom);
      shift_ir(ir);
      dmi_error_i = 2'($urandom);
      n = (ir_m == 1 || ir_m == 16 || ir_m == 17) ? 32 : int'($urandom_range(1, 32));
      shift_dr($urandom, n, $urandom);
    end

    shift_ir(5'h10);
    step(1, 0, 0, b); step(0, 0, 0, b); step(0, 0, 0, b);
    for (int i = 0; i < 5; i++) step(1, 1, 0, b);
    chk("tms5_tlr",   test_logic_reset_o, 1);
    chk("tms5_dtmcs", dtmcs_select_o, 0);
    chk("tms5_oe",    tdo_oe_o, 0);
    step(0, 0, 0, b);
    shift_dr($urandom, 32, 32'h0);

    shift_ir(5'h11);
    step(1, 0, 0, b); step(1, 0, 0, b); step(0, 0, 0, b); step(0, 0, 0, b);
    step(0, 1, 0, b); step(0, 1, 0, b);
    #3;
    trst_ni = 1'b0;
    #1;
    chk("trst_tlr",   test_logic_reset_o, 1);
    chk("trst_td_o",  td_o, 0);
    chk("trst_oe",    tdo_oe_o, 0);
    chk("trst_dmi",   dmi_access_o, 0);
    chk("trst_dtmcs", dtmcs_select_o, 0);
    @(negedge tck); #1;
    trst_ni = 1'b1;
    m_state = TLR;
    ir_m    = 1;
    step(0, 0, 0, b);
    shift_dr($urandom, 32, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
